// File: rtl/tdm_demux_rx.sv
// -----------------------------------------------------------------------------
// tdm_demux_rx -- receive side of the time-division mux link.
//
// Takes a serial bit stream carrying NCH channel slots of W bits per frame,
// aligns to frames using frame_sync, and routes each slot back into its own
// parallel channel register. Slot order on the wire is channel 0 first, each
// slot MSB first. Misplaced or missing syncs are flagged and recovered from.
//
// Optional feature (compile-time macro PARITY_EN):
//   defined   : each frame carries one trailing even-parity bit over all
//               NCH*W data bits; a mismatching frame is dropped and
//               parity_err_o pulses instead of out_valid_o.
//   undefined : no parity bit on the wire, parity_err_o is tied to 0.
//
// Ports:
//   clk           rising-edge clock for all logic
//   rst_n         synchronous reset, active low
//   in_bit_i      serial data bit, sampled only while in_valid_i=1
//   in_valid_i    qualifier for in_bit_i / frame_sync_i; state holds when 0
//   frame_sync_i  marks the current qualified bit as bit 0 of a frame
//   ch_data_o     channel c at [c*W +: W]; updated once per good frame
//   out_valid_o   1-cycle pulse: ch_data_o holds a new complete frame
//   sync_err_o    1-cycle pulse: misplaced or missing frame_sync
//   parity_err_o  1-cycle pulse: parity mismatch (PARITY_EN builds only)
// -----------------------------------------------------------------------------
module tdm_demux_rx #(
  parameter int NCH = 4,
  parameter int W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_bit_i,
  input  logic             in_valid_i,
  input  logic             frame_sync_i,
  output logic [NCH*W-1:0] ch_data_o,
  output logic             out_valid_o,
  output logic             sync_err_o,
  output logic             parity_err_o
);

  // Number of data bits per frame.
  localparam int ND = NCH * W;

`ifdef PARITY_EN
  // Data bits plus one trailing parity bit. The shift register holds every
  // data bit because the frame completes on the parity bit, after which no
  // more data arrives.
  localparam int F  = ND + 1;
  localparam int SW = ND;
`else
  // The final data bit is taken straight from in_bit_i on the completing
  // edge, so the shift register only has to keep the ND-1 bits before it.
  localparam int F  = ND;
  localparam int SW = ND - 1;
`endif

  localparam int CW = $clog2(F);

  typedef enum logic {
    HUNT = 1'b0,  // waiting for the first frame_sync
    RECV = 1'b1   // aligned, counting bits within a frame
  } state_e;

  state_e          state_q,     state_d;
  logic [CW-1:0]   cnt_q,       cnt_d;
  logic [SW-1:0]   shreg_q,     shreg_d;
  logic [ND-1:0]   ch_data_q,   ch_data_d;
  logic            out_valid_q, out_valid_d;
  logic            sync_err_q,  sync_err_d;

`ifdef PARITY_EN
  logic            par_q,        par_d;
  logic            parity_err_q, parity_err_d;
  logic            shift_en;
`endif

  logic [SW-1:0]   shreg_shift;  // shift register with the current bit appended
  logic [ND-1:0]   frame_bits;   // complete frame in wire order, first bit at MSB
  logic            cnt_zero;
  logic            last_bit;

  // Reorder a wire-order frame (channel 0 in the top W bits) into the output
  // layout (channel 0 in the bottom W bits). Bit order inside a slot is kept.
  function automatic logic [ND-1:0] slot_remap(input logic [ND-1:0] s);
    logic [ND-1:0] r;
    r = '0;
    for (int c = 0; c < NCH; c++) begin
      r[c*W +: W] = s[(NCH-1-c)*W +: W];
    end
    return r;
  endfunction

  // The cast keeps the low SW bits, i.e. drops the oldest bit.
  assign shreg_shift = SW'({shreg_q, in_bit_i});

`ifdef PARITY_EN
  assign frame_bits = shreg_q;
  // The parity bit itself is never shifted into the data register.
  assign shift_en   = (cnt_q < CW'(ND));
`else
  assign frame_bits = {shreg_q, in_bit_i};
`endif

  assign cnt_zero = (cnt_q == '0);
  assign last_bit = (cnt_q == CW'(F - 1));

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the block leaves one unassigned and no latch is inferred.
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    ch_data_d   = ch_data_q;
    out_valid_d = 1'b0;
    sync_err_d  = 1'b0;
`ifdef PARITY_EN
    par_d        = par_q;
    parity_err_d = 1'b0;
`endif

    if (in_valid_i) begin
      case (state_q)
        HUNT: begin
          // Everything before the first sync is noise; no error reported.
          if (frame_sync_i) begin
            state_d = RECV;
            cnt_d   = CW'(1);
            shreg_d = shreg_shift;
`ifdef PARITY_EN
            par_d   = in_bit_i;
`endif
          end
        end

        RECV: begin
          if (frame_sync_i && !cnt_zero) begin
            // Sync arrived mid-frame: drop the partial frame and realign on
            // this bit as the new bit 0.
            sync_err_d = 1'b1;
            cnt_d      = CW'(1);
            shreg_d    = shreg_shift;
`ifdef PARITY_EN
            par_d      = in_bit_i;
`endif
          end else if (!frame_sync_i && cnt_zero) begin
            // Expected sync is missing: alignment is lost, go back to hunting.
            sync_err_d = 1'b1;
            state_d    = HUNT;
          end else begin
`ifdef PARITY_EN
            if (shift_en) begin
              shreg_d = shreg_shift;
            end
            par_d = cnt_zero ? in_bit_i : (par_q ^ in_bit_i);
`else
            shreg_d = shreg_shift;
`endif
            if (last_bit) begin
              cnt_d = '0;
`ifdef PARITY_EN
              // Even parity: data bits plus parity bit must XOR to zero.
              if (par_q ^ in_bit_i) begin
                parity_err_d = 1'b1;
              end else begin
                ch_data_d   = slot_remap(frame_bits);
                out_valid_d = 1'b1;
              end
`else
              ch_data_d   = slot_remap(frame_bits);
              out_valid_d = 1'b1;
`endif
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end

        default: state_d = HUNT;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others, independent of statement order.
    if (!rst_n) begin
      // NOTE: the shift register is reset along with the control state so a
      // reset leaves no trace of a partial frame anywhere in the datapath.
      state_q     <= HUNT;
      cnt_q       <= '0;
      shreg_q     <= '0;
      ch_data_q   <= '0;
      out_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
`ifdef PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      ch_data_q   <= ch_data_d;
      out_valid_q <= out_valid_d;
      sync_err_q  <= sync_err_d;
`ifdef PARITY_EN
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign ch_data_o   = ch_data_q;
  assign out_valid_o = out_valid_q;
  assign sync_err_o  = sync_err_q;
`ifdef PARITY_EN
  assign parity_err_o = parity_err_q;
`else
  assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_demux_rx.sv
// -----------------------------------------------------------------------------
// tb_tdm_demux_rx -- testbench for tdm_demux_rx (NCH=4, W=8).
//
// The stimulus side feeds a reference model that works on whole frames as a
// list of received bits; every result it predicts is pushed into a scoreboard
// queue tagged with the cycle it must appear in. A monitor on the falling edge
// pops and compares, and also tracks the value ch_data must hold every cycle.
// Honour PARITY_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_tdm_demux_rx;

  localparam int NCH = 4;
  localparam int W   = 8;
  localparam int ND  = NCH * W;
`ifdef PARITY_EN
  localparam int F = ND + 1;
`else
  localparam int F = ND;
`endif

  typedef enum int {EV_VALID, EV_SERR, EV_PERR, EV_RESET} ev_kind_e;
  typedef struct {
    ev_kind_e      kind;
    logic [ND-1:0] data;
    int            cyc;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_bit;
  logic          in_valid;
  logic          frame_sync;
  logic [ND-1:0] ch_data;
  logic          out_valid;
  logic          sync_err;
  logic          parity_err;

  int  cyc      = 0;
  int  checks   = 0;
  int  failures = 0;

  ev_t           sb[$];
  ev_t           mon_e;
  logic [2:0]    mon_exp;
  logic [ND-1:0] exp_ch = '0;
  bit            mon_en = 1'b0;

  // Reference model state: hunting flag and bits collected for this frame.
  bit            m_hunt = 1'b1;
  bit            m_bits[$];

  tdm_demux_rx #(.NCH(NCH), .W(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_bit_i     (in_bit),
    .in_valid_i   (in_valid),
    .frame_sync_i (frame_sync),
    .ch_data_o    (ch_data),
    .out_valid_o  (out_valid),
    .sync_err_o   (sync_err),
    .parity_err_o (parity_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: applies the framing rules to one qualified bit.
  // ec is the cycle in which the resulting pulse must be visible.
  // ---------------------------------------------------------------------------
  task automatic model_bit(input bit b, input bit s, input int ec);
    logic [ND-1:0] d;
    bit            p;
    if (m_hunt) begin
      if (s) begin
        m_bits.delete();
        m_bits.push_back(b);
        m_hunt = 1'b0;
      end
    end else if (s && m_bits.size() != 0) begin
      sb.push_back('{EV_SERR, '0, ec});
      m_bits.delete();
      m_bits.push_back(b);
    end else if (!s && m_bits.size() == 0) begin
      sb.push_back('{EV_SERR, '0, ec});
      m_hunt = 1'b1;
    end else begin
      m_bits.push_back(b);
      if (m_bits.size() == F) begin
        d = '0;
        p = 1'b0;
        for (int k = 0; k < F; k++) p ^= m_bits[k];
        // Wire bit k belongs to channel k/W, bit position W-1-(k%W).
        for (int k = 0; k < ND; k++) d[(k / W) * W + (W - 1 - k % W)] = m_bits[k];
        if (F > ND && p) sb.push_back('{EV_PERR, '0, ec});
        else             sb.push_back('{EV_VALID, d, ec});
        m_bits.delete();
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus helpers. Inputs change 1 time unit after the rising edge, so the
  // value driven while cyc=c is sampled by the edge that makes cyc=c+1.
  // ---------------------------------------------------------------------------
  task automatic drive_bit(input bit b, input bit s);
    @(posedge clk); #1;
    in_valid   = 1'b1;
    in_bit     = b;
    frame_sync = s;
    model_bit(b, s, cyc + 1);
  endtask

  // Idle cycles carry random junk on in_bit/frame_sync, which must be ignored.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_valid   = 1'b0;
      in_bit     = 1'($urandom);
      frame_sync = 1'($urandom);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    sb.push_back('{EV_RESET, '0, cyc + 1});
    m_hunt = 1'b1;
    m_bits.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Send the first nbits wire bits of a frame carrying data (output layout),
  // sync on bit 0 if sync0, an idle gap before bit gap_at, optional bad parity.
  task automatic send_bits(input logic [ND-1:0] data, input int nbits, input bit sync0,
                           input int gap_at, input int gap_len, input bit flip);
    for (int k = 0; k < nbits; k++) begin
      bit b;
      if (gap_len > 0 && k == gap_at) idle(gap_len);
      if (k < ND) b = data[(k / W) * W + (W - 1 - k % W)];
      else        b = (^data) ^ flip;
      drive_bit(b, sync0 && (k == 0));
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (mon_en) begin
      mon_exp = 3'b000;
      if (sb.size() != 0 && sb[0].cyc == cyc) begin
        mon_e = sb.pop_front();
        case (mon_e.kind)
          EV_VALID: begin mon_exp = 3'b100; exp_ch = mon_e.data; end
          EV_SERR:  mon_exp = 3'b010;
          EV_PERR:  mon_exp = 3'b001;
          default:  exp_ch = '0;
        endcase
      end
      check("pulses{valid,serr,perr}", {61'd0, out_valid, sync_err, parity_err}, {61'd0, mon_exp});
      check("ch_data", 64'(ch_data), 64'(exp_ch));
    end
  end

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_bit     = 1'b0;
    frame_sync = 1'b0;
    sb.push_back('{EV_RESET, '0, 1});
    mon_en = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Bits without any sync: nothing may happen.
    repeat (10) drive_bit(1'($urandom), 1'b0);
    idle(3);
    check("no_sync_ch", 64'(ch_data), 64'd0);

    // Contiguous frame 0x11,0x22,0x33,0x44.
    send_bits(32'h44332211, F, 1'b1, 0, 0, 1'b0);
    idle(2);
    check("frame1_ch", 64'(ch_data), 64'h44332211);

    // Same frame with a 5-cycle gap in the middle of slot 2.
    send_bits(32'h44332211, F, 1'b1, 20, 5, 1'b0);
    idle(2);
    check("gap_frame_ch", 64'(ch_data), 64'h44332211);

    // Sync reappears at bit 13, then a clean frame 0xA1..0xA4.
    send_bits(32'h55667788, 13, 1'b1, 0, 0, 1'b0);
    send_bits(32'hA4A3A2A1, F, 1'b1, 0, 0, 1'b0);
    idle(2);
    check("resync_ch", 64'(ch_data), 64'hA4A3A2A1);

    // Back-to-back, frame 2 lacks its sync: error, hunt, ch_data keeps frame 1.
    send_bits(32'h0BADF00D, F, 1'b1, 0, 0, 1'b0);
    send_bits(32'h12121212, F, 1'b0, 0, 0, 1'b0);
    idle(2);
    check("nosync_keep_ch", 64'(ch_data), 64'h0BADF00D);
    send_bits(32'hCAFEBABE, F, 1'b1, 0, 0, 1'b0);
    idle(2);
    check("after_hunt_ch", 64'(ch_data), 64'hCAFEBABE);

`ifdef PARITY_EN
    send_bits(32'h12345678, F, 1'b1, 0, 0, 1'b0);
    idle(2);
    check("parity_ok_ch", 64'(ch_data), 64'h12345678);
    send_bits(32'h9ABCDEF0, F, 1'b1, 0, 0, 1'b1);
    idle(2);
    check("parity_bad_ch", 64'(ch_data), 64'h12345678);
`endif

    // Reset at bit 20 of a frame: partial frame dropped, ch_data cleared.
    send_bits(32'hDEADBEEF, 20, 1'b1, 0, 0, 1'b0);
    do_reset();
    check("reset_mid_ch", 64'(ch_data), 64'd0);
    send_bits(32'h01020304, F, 1'b1, 0, 0, 1'b0);
    idle(2);
    check("post_reset_ch", 64'(ch_data), 64'h01020304);

    // Randomised traffic: clean, gapped, truncated, junk, bad-parity frames
    // and occasional resets, with random idle between them.
    for (int it = 0; it < 60; it++) begin
      logic [ND-1:0] d;
      int            r;
      d = ND'({$urandom, $urandom});
      r = int'($urandom_range(0, 15));
      if (r == 0) begin
        do_reset();
      end else if (r < 3) begin
        send_bits(d, int'($urandom_range(1, F - 1)), 1'b1, 0, 0, 1'b0);
      end else if (r < 5) begin
        repeat ($urandom_range(1, 6)) drive_bit(1'($urandom), $urandom_range(0, 3) == 0);
      end else begin
        send_bits(d, F, 1'b1, int'($urandom_range(1, F - 1)),
                  (r < 8) ? int'($urandom_range(1, 4)) : 0, r == 15);
      end
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
    end

    idle(4);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
